// File: rtl/sram_rr_arbiter.sv
// -----------------------------------------------------------------------------
// sram_rr_arbiter
//
// Round-robin arbiter that lets NUM_REQ requesters share one single-port SRAM.
// Each requester offers a request on a valid/ready channel. Exactly one request
// (or none) is granted per cycle and driven straight onto the SRAM pins.
//
// A write grant is always followed by one idle SRAM cycle, which gives the
// macro its write-to-read turnaround. Reads can issue back to back. Read data
// returns one cycle after the grant and is tagged with a one-hot rsp_valid.
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   req_valid    per-requester request valid
//   req_wen      per-requester op (1 = write, 0 = read)
//   req_addr     packed addresses; requester i at [i*AW +: AW]
//   req_wdata    packed write data; requester i at [i*WIDTH +: WIDTH]
//   req_ready    one-hot grant (or zero); combinational
//   rsp_valid    one-hot read-data valid, one cycle after the read grant
//   rsp_data     read data (mem_q passed through)
//   mem_ren/wen  SRAM read / write enables (never both high)
//   mem_addr     SRAM address (0 when idle)
//   mem_d        SRAM write data (0 when not writing)
//   mem_q        SRAM read data
// -----------------------------------------------------------------------------
module sram_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 32,
    localparam int AW     = $clog2(DEPTH),
    localparam int PW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_wen,
    input  logic [NUM_REQ*AW-1:0]    req_addr,
    input  logic [NUM_REQ*WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     mem_ren,
    output logic                     mem_wen,
    output logic [AW-1:0]            mem_addr,
    output logic [WIDTH-1:0]         mem_d,
    input  logic [WIDTH-1:0]         mem_q
);

    // Unpacked views of the packed request buses.
    logic [AW-1:0]    addr_arr  [NUM_REQ];
    logic [WIDTH-1:0] wdata_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*AW +: AW];
            assign wdata_arr[gi] = req_wdata[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // State
    logic [PW-1:0]      prio_q, prio_d;
    logic               wr_bubble_q, wr_bubble_d;
    logic [NUM_REQ-1:0] rd_pending_q, rd_pending_d;

    // Grant selection
    logic               gnt_found;
    logic [PW-1:0]      gnt_idx;
    logic [NUM_REQ-1:0] gnt_onehot;
    logic [PW-1:0]      cand;

    // Scan from prio upward with wrap. The first valid requester wins.
    // Nothing is granted while in reset or during the post-write bubble.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = PW'((int'(prio_q) + k) % NUM_REQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
        if (rst || wr_bubble_q) begin
            gnt_found = 1'b0;
            gnt_idx   = '0;
        end
    end

    always_comb begin
        gnt_onehot = '0;
        if (gnt_found) begin
            gnt_onehot[gnt_idx] = 1'b1;
        end
    end

    // SRAM drive. ren and wen come from the single granted op, so they are
    // mutually exclusive by construction.
    always_comb begin
        mem_wen  = gnt_found & req_wen[gnt_idx];
        mem_ren  = gnt_found & ~req_wen[gnt_idx];
        mem_addr = gnt_found ? addr_arr[gnt_idx] : '0;
        mem_d    = (gnt_found && req_wen[gnt_idx]) ? wdata_arr[gnt_idx] : '0;
    end

    assign req_ready = gnt_onehot;
    assign rsp_valid = rd_pending_q;
    assign rsp_data  = mem_q;

    // Next-state logic
    always_comb begin
        prio_d       = prio_q;
        wr_bubble_d  = 1'b0;
        rd_pending_d = '0;
        if (gnt_found) begin
            if (int'(gnt_idx) == NUM_REQ - 1) begin
                prio_d = '0;
            end else begin
                prio_d = gnt_idx + PW'(1);
            end
            wr_bubble_d = req_wen[gnt_idx];
            if (!req_wen[gnt_idx]) begin
                rd_pending_d = gnt_onehot;
            end
        end
    end

    // rd_pending_q is still visible during the first reset cycle, so a
    // response already in flight is delivered before the clear takes effect.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q       <= '0;
            wr_bubble_q  <= 1'b0;
            rd_pending_q <= '0;
        end else begin
            prio_q       <= prio_d;
            wr_bubble_q  <= wr_bubble_d;
            rd_pending_q <= rd_pending_d;
        end
    end

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_rr_arbiter
//
// Bench for sram_rr_arbiter with NUM_REQ=2, WIDTH=32, DEPTH=32.
// A behavioural SRAM sits on the mem_* pins. A reference model tracks the
// priority index, the write bubble, the pending read and a shadow copy of
// the memory. It predicts every output each cycle.
// Directed scenarios run first, followed by a randomized run in which every
// requester keeps its request stable until it is accepted.
// -----------------------------------------------------------------------------
module tb_sram_rr_arbiter;

    localparam int N  = 2;
    localparam int W  = 32;
    localparam int D  = 32;
    localparam int AW = $clog2(D);

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_wen;
    logic [N*AW-1:0] req_addr;
    logic [N*W-1:0]  req_wdata;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [W-1:0]    rsp_data;
    logic            mem_ren;
    logic            mem_wen;
    logic [AW-1:0]   mem_addr;
    logic [W-1:0]    mem_d;
    logic [W-1:0]    mem_q;

    always #5 clk = ~clk;

    sram_rr_arbiter #(.NUM_REQ(N), .WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_wen   (req_wen),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_d     (mem_d),
        .mem_q     (mem_q)
    );

    // Behavioural single-port SRAM with registered read.
    // While preload is high, location a is set to a*0x11.
    logic [W-1:0] sram [D];
    logic         preload;

    always @(posedge clk) begin
        if (preload) begin
            for (int a = 0; a < D; a++) sram[a] <= W'(a * 32'h11);
        end else begin
            if (mem_wen) sram[mem_addr] <= mem_d;
            if (mem_ren) mem_q <= sram[mem_addr];
        end
    end

    // Reference model state
    int           m_prio;
    bit           m_bubble;
    int           m_pend_req;
    logic [W-1:0] m_pend_data;
    logic [W-1:0] shadow [D];
    int           last_gnt;
    int           tests;
    int           fails;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input bit v, input bit w, input int a, input logic [W-1:0] d);
        req_valid[i]          = v;
        req_wen[i]            = w;
        req_addr[i*AW +: AW]  = AW'(a);
        req_wdata[i*W +: W]   = d;
    endtask

    // One clock cycle: predict and check every output, advance the model,
    // then move to one time unit after the next rising edge.
    task automatic step();
        int           g;
        int           idx;
        int           ga;
        logic [W-1:0] gd;
        logic [N-1:0] er;
        #2;
        g = -1;
        if (!rst && !m_bubble) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_prio + k) % N;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        ga = (g >= 0) ? int'(req_addr[g*AW +: AW]) : 0;
        gd = (g >= 0) ? req_wdata[g*W +: W] : '0;
        er = (g >= 0) ? N'(1 << g) : '0;
        chk("req_ready", req_ready, er);
        chk("mem_wen", mem_wen, (g >= 0) && req_wen[g]);
        chk("mem_ren", mem_ren, (g >= 0) && !req_wen[g]);
        chk("ren_wen_excl", mem_ren & mem_wen, 0);
        chk("mem_addr", mem_addr, ga);
        if (g < 0 || req_wen[g]) chk("mem_d", mem_d, gd);
        chk("rsp_valid", rsp_valid, (m_pend_req >= 0) ? (1 << m_pend_req) : 0);
        if (m_pend_req >= 0) chk("rsp_data", rsp_data, m_pend_data);
        if (g >= 0)
            $display("[TB] t=%0t grant req%0d %s addr=%0d data=%h", $time, g,
                     req_wen[g] ? "wr" : "rd", ga, gd);
        if (m_pend_req >= 0)
            $display("[TB] t=%0t resp req%0d data=%h", $time, m_pend_req, m_pend_data);
        last_gnt = g;
        if (rst) begin
            m_prio     = 0;
            m_bubble   = 1'b0;
            m_pend_req = -1;
        end else begin
            m_bubble   = 1'b0;
            m_pend_req = -1;
            if (g >= 0) begin
                m_prio = (g + 1) % N;
                if (req_wen[g]) begin
                    shadow[ga] = gd;
                    m_bubble   = 1'b1;
                end else begin
                    m_pend_req  = g;
                    m_pend_data = shadow[ga];
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        m_prio     = 0;
        m_bubble   = 1'b0;
        m_pend_req = -1;
        last_gnt   = -1;
        for (int a = 0; a < D; a++) shadow[a] = W'(a * 32'h11);

        // Reset with both requesters valid
        rst       = 1'b1;
        preload   = 1'b1;
        req_valid = '0;
        req_wen   = '0;
        req_addr  = '0;
        req_wdata = '0;
        @(posedge clk);
        #1;
        preload = 1'b0;
        set_req(0, 1, 0, 1, 0);
        set_req(1, 1, 0, 2, 0);
        #1 chk("rst_ready", req_ready, 0);
        chk("rst_ren_wen", {mem_ren, mem_wen}, 0);
        step();
        step();
        rst = 1'b0;
        #1 chk("first_grant_req0", req_ready, 2'b01);
        step();
        set_req(0, 0, 0, 0, 0);
        step();
        set_req(1, 0, 0, 0, 0);
        step();

        // Write then read by requester 0
        set_req(0, 1, 1, 5, 32'hDEADBEEF);
        #1 chk("wr_mem_wen", mem_wen, 1);
        chk("wr_mem_addr", mem_addr, 5);
        step();
        set_req(0, 1, 0, 5, 0);
        #1 chk("turnaround_ready", req_ready, 0);
        step();
        #1 chk("rd_mem_ren", mem_ren, 1);
        step();
        set_req(0, 0, 0, 0, 0);
        #1 chk("rd_rsp_valid", rsp_valid, 2'b01);
        chk("rd_rsp_data", rsp_data, 32'hDEADBEEF);
        step();
        // A single read by requester 1 moves prio back to 0.
        set_req(1, 1, 0, 2, 0);
        step();
        set_req(1, 0, 0, 0, 0);
        step();

        // Round robin between two continuous readers
        set_req(0, 1, 0, 1, 0);
        set_req(1, 1, 0, 2, 0);
        for (int c = 0; c < 6; c++) begin
            #1 chk("rr_grant", req_ready, (c % 2) ? 2'b10 : 2'b01);
            if (c > 0) begin
                chk("rr_rsp_valid", rsp_valid, (c % 2) ? 2'b01 : 2'b10);
                chk("rr_rsp_data", rsp_data, (c % 2) ? 32'h11 : 32'h22);
            end
            step();
        end
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        #1 chk("rr_last_rsp", rsp_valid, 2'b10);
        step();

        // Write contention
        set_req(0, 1, 1, 3, 32'hA);
        set_req(1, 1, 1, 4, 32'hB);
        #1 chk("wc_grant0", req_ready, 2'b01);
        step();
        set_req(0, 0, 0, 0, 0);
        #1 chk("wc_idle", {req_ready, mem_ren, mem_wen}, 0);
        step();
        #1 chk("wc_grant1", req_ready, 2'b10);
        step();
        set_req(0, 1, 0, 3, 0);
        set_req(1, 1, 0, 4, 0);
        step();
        step();
        set_req(0, 0, 0, 0, 0);
        #1 chk("wc_rd_a_valid", rsp_valid, 2'b01);
        chk("wc_rd_a_data", rsp_data, 32'hA);
        step();

        // Reset while a read response is in flight. Requester 1's read of
        // addr 4 was granted in the previous cycle, and its request stays valid.
        rst = 1'b1;
        #1 chk("rst_mid_rsp_valid", rsp_valid, 2'b10);
        chk("rst_mid_rsp_data", rsp_data, 32'hB);
        chk("rst_mid_no_grant", req_ready, 0);
        step();
        #1 chk("rst_mid_rsp_clear", rsp_valid, 0);
        step();
        rst = 1'b0;
        set_req(0, 1, 0, 3, 0);
        #1 chk("post_rst_grant", req_ready, 2'b01);
        step();

        // Idle period; prio is held at 1
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        for (int c = 0; c < 10; c++) step();
        set_req(0, 1, 0, 7, 0);
        set_req(1, 1, 0, 9, 0);
        #1 chk("post_idle_grant", req_ready, 2'b10);
        step();

        // Randomized traffic. A requester draws a new op only when idle or
        // just accepted.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || last_gnt == i)
                    set_req(i, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                            int'($urandom_range(0, 7)), $urandom);
            end
            step();
        end
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sram_rr_arbiter.md
Name: sram_rr_arbiter

Overview:
Round-robin arbiter that shares one single_port_sram instance among NUM_REQ requesters using valid/ready request channels. It drives the SRAM's ren/wen/addr/d pins and never asserts ren and wen together. It inserts the write-to-read turnaround the SRAM needs and routes each read result back to its issuer one cycle after the grant. It sits between HLS-generated loop bodies and a shared buffer.

Parameters:
NUM_REQ, 2, number of requesters (1..8)
WIDTH, 32, data width; must match the SRAM WIDTH
DEPTH, 32, SRAM depth; AW = $clog2(DEPTH) is the address width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  NUM_REQ  per-requester request valid
req_wen  in  NUM_REQ  per-requester op: 1 = write, 0 = read
req_addr  in  NUM_REQ*AW  packed addresses; requester i at [i*AW +: AW]
req_wdata  in  NUM_REQ*WIDTH  packed write data; requester i at [i*WIDTH +: WIDTH]
req_ready  out  NUM_REQ  grant; one-hot or zero
rsp_valid  out  NUM_REQ  read data valid for requester i; one-hot or zero
rsp_data  out  WIDTH  read data; meaningful only when rsp_valid != 0
mem_ren  out  1  to SRAM ren
mem_wen  out  1  to SRAM wen
mem_addr  out  AW  to SRAM addr
mem_d  out  WIDTH  to SRAM d
mem_q  in  WIDTH  from SRAM q

Behaviour:
- Handshake and requester obligations:
  - A transfer occurs in any cycle where req_valid[i] & req_ready[i].
  - req_ready is combinational from req_valid, the priority pointer and the turnaround flag.
  - Once req_valid[i] rises, requester i holds valid, wen, addr and wdata stable until it is accepted.
- Arbitration state:
  - prio: a log2(NUM_REQ)-bit register holding the highest-priority index. Reset value 0.
  - Grant goes to the first valid requester at or after prio, in increasing index order with wrap.
  - After a grant to requester g, prio <= (g+1) mod NUM_REQ. With no grant, prio holds.
- Turnaround state:
  - wr_bubble: 1-bit register. Set in the cycle following any write grant, cleared otherwise.
  - While wr_bubble = 1: req_ready = 0, mem_ren = mem_wen = 0, prio holds.
  - Result: a write is followed by at least one idle SRAM cycle. Back-to-back reads are allowed at full rate.
- SRAM drive, combinational in the grant cycle:
  - Granted write: mem_wen=1, mem_addr=req_addr[g], mem_d=req_wdata[g].
  - Granted read: mem_ren=1, mem_addr=req_addr[g].
  - No grant: mem_ren=0 and mem_wen=0; mem_addr and mem_d are don't-care, driven 0.
  - mem_ren & mem_wen is never 1.
- Read response:
  - rd_pending[NUM_REQ-1:0] register <= one-hot of the requester granted a read this cycle, else 0.
  - rsp_valid = rd_pending.
  - rsp_data = mem_q, passed through combinationally.
  - Read latency: exactly 1 cycle from the accept cycle. There is no response backpressure; the requester must consume in that cycle.
- Reset:
  - While rst=1: req_ready=0, mem_ren=mem_wen=0.
  - At the clock edge: prio<=0, wr_bubble<=0, rd_pending<=0.
  - Reset outputs: req_ready=0, rsp_valid=0, mem_ren=0, mem_wen=0, mem_addr=0, mem_d=0.
  - Reset mid-operation: a response already registered is still presented in the cycle rst is first high. No grant is issued in any cycle where rst=1.
- Boundaries:
  - NUM_REQ=1: prio is fixed at 0; turnaround still applies.
  - Addresses >= DEPTH are passed through unchecked.
  - Simultaneous read and write requests are arbitrated purely by prio; the op type carries no priority.

Test Plan:
- Reset: rst=1 for 2 cycles with req_valid=2'b11 -> req_ready=0, mem_ren=mem_wen=0, rsp_valid=0. After release with both requesters valid, the first grant goes to requester 0.
- Write then read, requester 0:
  - Cycle 0: write addr 5, data 0xDEADBEEF -> mem_wen=1, mem_addr=5.
  - Cycle 1: read addr 5 is presented -> req_ready=0 (turnaround).
  - Cycle 2: mem_ren=1.
  - Cycle 3: rsp_valid=2'b01, rsp_data=0xDEADBEEF.
- Round robin:
  - Setup: SRAM preloaded with [1]=0x11, [2]=0x22. Requester 0 reads addr 1 and requester 1 reads addr 2, both continuously valid.
  - Grants alternate 0,1,0,1 with no gaps.
  - rsp_valid alternates 01,10 with rsp_data 0x11,0x22, each lagging its grant by 1 cycle.
- Write contention: both requesters write in the same cycle (req0 addr 3 = 0xA, req1 addr 4 = 0xB).
  - Cycle 0: grant req0.
  - Cycle 1: idle.
  - Cycle 2: grant req1.
  - Subsequent reads return 0xA and 0xB.
  - An assertion checks that mem_ren & mem_wen never fires.
- Reset mid-read: read granted in cycle t, rst=1 in cycle t+1 with req_valid held.
  - Cycle t+1: rsp_valid still asserted with the correct data; no new grant.
  - Cycle t+2: rsp_valid=0.
  - After release, the grant goes to requester 0 (prio back at 0).
- Idle: req_valid=0 for 10 cycles -> mem_ren=mem_wen=0, rsp_valid=0, and the next grant follows the prio value held from before the idle period.
